vector_load_unit: RTL and testbench

VECTOR_LOAD_UNIT -- requirements
Module: vector_load_unit

---
 rtl/vlu_pkg.sv | 18 +
 rtl/vlu_byte_assembler.sv | 38 +++
 rtl/vector_load_unit.sv | 126 ++++++++++++
 tb/tb_vector_load_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vlu_pkg.sv
// Shared types and constants for the vector load unit: FSM state encoding,
// lane geometry and the default reserved register index.
package vlu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WR   = 2'd3
  } vlu_state_e;

  localparam int LANES  = 8;
  localparam int VEC_W  = 64;
  localparam int LANE_W = $clog2(LANES);

  localparam logic [4:0] RSV_REG_DEFAULT = 5'b11111;

endpackage

// File: rtl/vlu_byte_assembler.sv
// Byte-lane assembly register: clears at command accept and inserts one
// response byte per load strobe into the lane selected by i_lane.
module vlu_byte_assembler
  import vlu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [7:0]        i_byte,
  output logic [VEC_W-1:0]  o_vec_next
);

  logic [VEC_W-1:0] r_vec;
  logic [VEC_W-1:0] w_vec_ins;

  // Vector as it will look once the current byte is inserted
  always_comb begin
    w_vec_ins = r_vec;
    w_vec_ins[{i_lane, 3'b000} +: 8] = i_byte;
  end

  assign o_vec_next = w_vec_ins;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec <= '0;
    end else if (i_clear) begin
      r_vec <= '0;
    end else if (i_load) begin
      r_vec <= w_vec_ins;
    end else begin
      r_vec <= r_vec;
    end
  end

endmodule

// File: rtl/vector_load_unit.sv
// Gathers eight bytes from a byte-wide memory port into a 64-bit vector
// register write. Optional feature macro: VLU_RSV_GUARD_EN (skip reserved dest).
module vector_load_unit
  import vlu_pkg::*;
#(
  parameter int         ADDR_W  = 16,
  parameter logic [4:0] RSV_REG = RSV_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_dest,
  input  logic [ADDR_W-1:0] cmd_base,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [7:0]        mem_rsp_data,
  output logic [VEC_W-1:0]  write_data,
  output logic [4:0]        write_addr,
  output logic              write_enable,
  output logic              busy,
  output logic              done
);

  vlu_state_e        r_state;
  logic [LANE_W-1:0] r_idx;
  logic [4:0]        r_dest;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [VEC_W-1:0]  r_wdata;
  logic              r_we;
  logic              r_done;

  logic              w_accept;
  logic              w_rsp_take;
  logic [LANE_W-1:0] w_idx_nxt;
  logic [VEC_W-1:0]  w_vec_next;

  assign w_accept   = cmd_valid && (r_state == ST_IDLE);
  assign w_rsp_take = mem_rsp_valid && (r_state == ST_WAIT);
  assign w_idx_nxt  = r_idx + {{(LANE_W-1){1'b0}}, 1'b1};

  vlu_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_accept),
    .i_load     (w_rsp_take),
    .i_lane     (r_idx),
    .i_byte     (mem_rsp_data),
    .o_vec_next (w_vec_next)
  );

  // Sequencer: one request in flight, one byte per WAIT, a single write cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_dest  <= 5'd0;
      r_base  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_dest <= cmd_dest;
            r_base <= cmd_base;
            r_addr <= cmd_base;
            r_idx  <= '0;
`ifdef VLU_RSV_GUARD_EN
            if (cmd_dest == RSV_REG) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_REQ;
            end
`else
            r_state <= ST_REQ;
`endif
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            if (r_idx == LANE_W'(LANES - 1)) begin
              r_state <= ST_WR;
              r_wdata <= w_vec_next;
              r_we    <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              // Address wraps silently at 2^ADDR_W
              r_idx   <= w_idx_nxt;
              r_addr  <= r_base + ADDR_W'(w_idx_nxt);
              r_state <= ST_REQ;
            end
          end
        end
        ST_WR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_req_addr  = r_addr;
  assign write_data    = r_wdata;
  assign write_addr    = r_dest;
  assign write_enable  = r_we;
  assign done          = r_done;

endmodule

// File: tb/tb_vector_load_unit.sv
// Directed self-checking bench for vector_load_unit with a zero-wait byte
// memory responder; covers normal, backpressure, wrap, reset, stray, guard.
module tb_vector_load_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_dest = 5'd0;
  logic [15:0] cmd_base = 16'd0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [15:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [7:0]  mem_rsp_data = 8'd0;
  logic [63:0] write_data;
  logic [4:0]  write_addr;
  logic        write_enable;
  logic        busy;
  logic        done;

  vector_load_unit dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dest      (cmd_dest),
    .cmd_base      (cmd_base),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .write_data    (write_data),
    .write_addr    (write_addr),
    .write_enable  (write_enable),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;
  int          n_we = 0;
  int          n_done = 0;
  int          n_done_we = 0;
  int          n_reqv = 0;
  int          we_cyc = 0;
  int          acc_cyc = 0;
  logic [4:0]  last_waddr = 5'd0;
  logic [63:0] last_wdata = 64'd0;
  logic [15:0] addr_log [16];
  int          n_log = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Negedge monitor: the register file samples writes on this edge
  always @(negedge clk) begin
    if (!rst) begin
      if (write_enable) begin
        n_we       <= n_we + 1;
        last_waddr <= write_addr;
        last_wdata <= write_data;
        we_cyc     <= cyc;
      end
      if (done) n_done <= n_done + 1;
      if (done && write_enable) n_done_we <= n_done_we + 1;
      if (mem_req_valid) n_reqv <= n_reqv + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic send_cmd(input logic [4:0] d, input logic [15:0] b);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_dest  = d;
    cmd_base  = b;
    acc_cyc   = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Byte memory responder; ends at the write negedge or after lane stop_lane
  task automatic service(input logic [63:0] data, input logic [15:0] base,
                         input int stall_lane, input int stall_n, input int stop_lane);
    int  lane;
    int  stalls;
    bit  pend;
    bit  fin;
    logic [15:0] e_addr;
    lane = 0; stalls = 0; pend = 0; fin = 0; n_log = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      if (write_enable) begin
        fin = 1;
      end else if (pend) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data[lane*8 +: 8];
        pend = 0;
        if (lane == stop_lane) fin = 1;
        lane++;
      end else if (mem_req_valid) begin
        if (lane == stall_lane && stalls < stall_n) begin
          mem_req_ready = 1'b0;
          stalls++;
          e_addr = base + 16'(stall_lane);
          chk("stall_addr", mem_req_addr, e_addr);
        end else begin
          if (n_log < 16) addr_log[n_log] = mem_req_addr;
          n_log++;
          pend = 1;
        end
      end
      if (!fin) @(negedge clk);
    end
    chk("service_end", fin, 1);
  endtask

  task automatic chk_addrs(input string tag, input logic [15:0] base);
    logic [15:0] e;
    chk({tag, "_nreq"}, n_log, 8);
    for (int k = 0; k < 8; k++) begin
      e = base + 16'(k);
      chk(tag, addr_log[k], e);
    end
  endtask

  int we0, done0, req0, dwe0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_done", done, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_waddr", write_addr, 0);

    // Zero-wait load
    we0 = n_we; done0 = n_done; dwe0 = n_done_we; req0 = n_reqv;
    send_cmd(5'd3, 16'h0100);
    chk("t1_busy", busy, 1);
    service(64'h8877665544332211, 16'h0100, -1, 0, 99);
    @(negedge clk);
    chk("t1_we_cnt", n_we - we0, 1);
    chk("t1_done_cnt", n_done - done0, 1);
    chk("t1_done_with_we", n_done_we - dwe0, 1);
    chk("t1_req_cycles", n_reqv - req0, 8);
    chk("t1_waddr", last_waddr, 3);
    chk("t1_wdata", last_wdata, 64'h8877665544332211);
    chk("t1_latency", we_cyc - acc_cyc - 1, 16);
    chk_addrs("t1_addr", 16'h0100);
    chk("gap_ready", cmd_ready, 1);
    chk("gap_we_low", write_enable, 0);
    chk("hold_wdata", write_data, 64'h8877665544332211);

    // Backpressure on lane 2, accepted right after the done cycle
    we0 = n_we; req0 = n_reqv;
    send_cmd(5'd5, 16'h0100);
    chk("t2_hold_old_wdata", write_data, 64'h8877665544332211);
    service(64'hF0E0D0C0B0A09080, 16'h0100, 2, 3, 99);
    @(negedge clk);
    chk("t2_we_cnt", n_we - we0, 1);
    chk("t2_req_cycles", n_reqv - req0, 11);
    chk("t2_waddr", last_waddr, 5);
    chk("t2_wdata", last_wdata, 64'hF0E0D0C0B0A09080);
    chk_addrs("t2_addr", 16'h0100);

    // Address wrap
    send_cmd(5'd1, 16'hFFFE);
    service(64'h0706050403020100, 16'hFFFE, -1, 0, 99);
    @(negedge clk);
    chk("t3_wdata", last_wdata, 64'h0706050403020100);
    chk("t3_addr_ffff", addr_log[1], 16'hFFFF);
    chk("t3_addr_0000", addr_log[2], 16'h0000);
    chk_addrs("t3_addr", 16'hFFFE);

    // Stray response while idle
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 8'hAA;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_ready", cmd_ready, 1);
    chk("t4_wdata_hold", write_data, 64'h0706050403020100);
    send_cmd(5'd2, 16'h0400);
    service(64'h1234567890ABCDEF, 16'h0400, -1, 0, 99);
    @(negedge clk);
    chk("t4_wdata", last_wdata, 64'h1234567890ABCDEF);

    // Reset after the lane-4 response
    we0 = n_we; done0 = n_done;
    send_cmd(5'd7, 16'h0200);
    service(64'h5555555555555555, 16'h0200, -1, 0, 4);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_busy_in_rst", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_no_we", n_we - we0, 0);
    chk("t5_no_done", n_done - done0, 0);
    chk("t5_wdata_cleared", write_data, 0);
    send_cmd(5'd9, 16'h0300);
    service(64'hCAFEBABEDEADBEEF, 16'h0300, -1, 0, 99);
    @(negedge clk);
    chk("t5_next_waddr", last_waddr, 9);
    chk("t5_next_wdata", last_wdata, 64'hCAFEBABEDEADBEEF);

    // Reserved destination
    we0 = n_we; req0 = n_reqv; done0 = n_done;
`ifdef VLU_RSV_GUARD_EN
    send_cmd(5'd31, 16'h0500);
    chk("t6_done_next", done, 1);
    chk("t6_busy", busy, 0);
    @(negedge clk);
    chk("t6_done_pulse", done, 0);
    repeat (4) @(negedge clk);
    chk("t6_no_req", n_reqv - req0, 0);
    chk("t6_no_we", n_we - we0, 0);
    chk("t6_done_cnt", n_done - done0, 1);
`else
    send_cmd(5'd31, 16'h0500);
    service(64'h0102030405060708, 16'h0500, -1, 0, 99);
    @(negedge clk);
    chk("t6_req_cycles", n_reqv - req0, 8);
    chk("t6_we_cnt", n_we - we0, 1);
    chk("t6_waddr", last_waddr, 31);
    chk("t6_wdata", last_wdata, 64'h0102030405060708);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
